// File: rtl/bubble_pkg.sv
// Shared sizes, LFSR definition and the per-slot bubble record for the bubble field.
package bubble_pkg;

    localparam int unsigned NUM_BUBBLES = 7;
    localparam int unsigned SCREEN_W    = 160;
    localparam int unsigned SCREEN_H    = 120;
    localparam int unsigned X_W         = $clog2(SCREEN_W);
    localparam int unsigned Y_W         = $clog2(SCREEN_H);
    localparam int unsigned LFSR_W      = 8;
    localparam int unsigned CMP_W       = 9;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 of a 1-based Fibonacci register map to bits 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    typedef struct packed {
        logic           active;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } bubble_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bubble_slot.sv
// One bubble: owns its active/x/y state, rises or retires each frame, and tests itself against the swimmer.
module bubble_slot
    import bubble_pkg::*;
#(
    parameter int unsigned SPEED    = 1,
    parameter int unsigned Y_BOTTOM = 112,
    parameter int unsigned Y_TOP    = 4,
    parameter int unsigned BUB_SIZE = 8,
    parameter int unsigned SWIM_W   = 16,
    parameter int unsigned SWIM_H   = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze,
    input  logic           spawn,
    input  logic [X_W-1:0] spawn_x,
    input  logic [X_W-1:0] swim_x,
    input  logic [Y_W-1:0] swim_y,
    output bubble_t        bubble,
    output logic           collision
);

    // y - SPEED >= Y_TOP rewritten as y >= SPEED + Y_TOP so nothing can wrap.
    localparam logic [Y_W:0] RISE_FLOOR = (Y_W + 1)'(SPEED + Y_TOP);

    logic             can_rise;
    logic             overlap;
    logic [CMP_W-1:0] bx;
    logic [CMP_W-1:0] by;
    logic [CMP_W-1:0] sx;
    logic [CMP_W-1:0] sy;

    always_comb begin
        can_rise = {1'b0, bubble.y} >= RISE_FLOOR;
        bx       = CMP_W'(bubble.x);
        by       = CMP_W'(bubble.y);
        sx       = CMP_W'(swim_x);
        sy       = CMP_W'(swim_y);
        overlap  = (sx < bx + CMP_W'(BUB_SIZE)) && (bx < sx + CMP_W'(SWIM_W)) &&
                   (sy < by + CMP_W'(BUB_SIZE)) && (by < sy + CMP_W'(SWIM_H));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble    <= '0;
            collision <= 1'b0;
        end else if (freeze) begin
            collision <= 1'b0;
        end else begin
            collision <= bubble.active & overlap;
            if (bubble.active) begin
                // A retiring bubble keeps its last position; only the flag drops.
                if (can_rise) begin
                    bubble.y <= bubble.y - Y_W'(SPEED);
                end else begin
                    bubble.active <= 1'b0;
                end
            end else if (spawn) begin
                bubble.active <= 1'b1;
                bubble.x      <= spawn_x;
                bubble.y      <= Y_W'(Y_BOTTOM);
            end
        end
    end

endmodule

// File: rtl/bubble_field.sv
// Bubble field top: LFSR, spawn timer, lowest-free-slot selection and freeze gating around the slots.
module bubble_field
    import bubble_pkg::*;
#(
    parameter int unsigned SPAWN_GAP = 30,
    parameter int unsigned SPEED     = 1,
    parameter int unsigned Y_BOTTOM  = 112,
    parameter int unsigned Y_TOP     = 4,
    parameter int unsigned BUB_SIZE  = 8,
    parameter int unsigned SWIM_W    = 16,
    parameter int unsigned SWIM_H    = 12,
    parameter int unsigned NUM_SLOTS = NUM_BUBBLES
) (
    input  logic                       fps,
    input  logic                       reset,
    input  logic                       freeze,
    input  logic [X_W-1:0]             swim_x,
    input  logic [Y_W-1:0]             swim_y,
    output logic [NUM_BUBBLES-1:0]     collisions,
    output logic [NUM_BUBBLES-1:0]     bubble_active,
    output logic [NUM_BUBBLES*X_W-1:0] bubble_x,
    output logic [NUM_BUBBLES*Y_W-1:0] bubble_y
);

    localparam int unsigned TIMER_W     = (SPAWN_GAP > 2) ? $clog2(SPAWN_GAP) : 1;
    localparam int unsigned SPAWN_X_OFS = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SPAWN_GAP - 1);

    logic [LFSR_W-1:0]    lfsr;
    logic [TIMER_W-1:0]   timer;
    logic                 spawn_due;
    logic [X_W-1:0]       spawn_x;
    logic [NUM_SLOTS-1:0] live;
    logic [NUM_SLOTS-1:0] spawn_sel;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic                 found;
    bubble_t              slot_state [NUM_SLOTS];

    assign spawn_due = (timer == TIMER_LAST);
    assign spawn_x   = X_W'({1'b0, lfsr[LFSR_W-2:0]}) + X_W'(SPAWN_X_OFS);

    // Frame-rate LFSR and spawn timer; both stand still while frozen.
    always_ff @(posedge fps or posedge reset) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            timer <= '0;
        end else if (!freeze) begin
            lfsr  <= lfsr_next(lfsr);
            timer <= spawn_due ? '0 : timer + TIMER_W'(1);
        end
    end

    // Lowest-index free slot, judged on pre-edge flags so a retiring slot is never reused this edge.
    always_comb begin
        spawn_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (spawn_due && !found && !live[i]) begin
                spawn_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_BUBBLES); i++) begin : g_slot
        if (i < int'(NUM_SLOTS)) begin : g_used
            bubble_slot #(
                .SPEED    (SPEED),
                .Y_BOTTOM (Y_BOTTOM),
                .Y_TOP    (Y_TOP),
                .BUB_SIZE (BUB_SIZE),
                .SWIM_W   (SWIM_W),
                .SWIM_H   (SWIM_H)
            ) u_slot (
                .clk       (fps),
                .rst       (reset),
                .freeze    (freeze),
                .spawn     (spawn_sel[i]),
                .spawn_x   (spawn_x),
                .swim_x    (swim_x),
                .swim_y    (swim_y),
                .bubble    (slot_state[i]),
                .collision (slot_hit[i])
            );

            assign live[i]                   = slot_state[i].active;
            assign collisions[i]             = slot_hit[i];
            assign bubble_active[i]          = slot_state[i].active;
            assign bubble_x[i*X_W +: X_W]    = slot_state[i].x;
            assign bubble_y[i*Y_W +: Y_W]    = slot_state[i].y;
        end else begin : g_unused
            assign collisions[i]             = 1'b0;
            assign bubble_active[i]          = 1'b0;
            assign bubble_x[i*X_W +: X_W]    = '0;
            assign bubble_y[i*Y_W +: Y_W]    = '0;
        end
    end

endmodule

// File: tb/tb_bubble_field.sv
// Directed bench for bubble_field: spawn timing, rise/retire, collision level, freeze and async reset.
module tb_bubble_field;

    logic        fps = 1'b0;
    logic        reset;
    logic        freeze;
    logic [7:0]  swim_x;
    logic [6:0]  swim_y;
    logic [6:0]  collisions, bubble_active;
    logic [55:0] bubble_x;
    logic [48:0] bubble_y;
    logic [6:0]  f_coll, f_act;
    logic [55:0] f_x;
    logic [48:0] f_y;

    int checks = 0;
    int passed = 0;
    int nf     = 0;

    typedef struct {
        int         edge_n;
        logic [6:0] act;
        logic [6:0] y0;
    } vec_t;

    vec_t tbl [8];

    always #5 fps = ~fps;

    bubble_field dut (
        .fps           (fps),
        .reset         (reset),
        .freeze        (freeze),
        .swim_x        (swim_x),
        .swim_y        (swim_y),
        .collisions    (collisions),
        .bubble_active (bubble_active),
        .bubble_x      (bubble_x),
        .bubble_y      (bubble_y)
    );

    bubble_field #(.SPAWN_GAP(2), .SPEED(1)) dut_fast (
        .fps           (fps),
        .reset         (reset),
        .freeze        (freeze),
        .swim_x        (swim_x),
        .swim_y        (swim_y),
        .collisions    (f_coll),
        .bubble_active (f_act),
        .bubble_x      (f_x),
        .bubble_y      (f_y)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (frame %0d)", name, got, exp, nf);
    endtask

    // LFSR value after n unfrozen frames from reset.
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    // x given to a bubble spawned on unfrozen frame f (uses the pre-edge LFSR).
    function automatic logic [7:0] spawn_x_at(input int f);
        logic [7:0] s;
        s = lfsr_after(f - 1);
        return {1'b0, s[6:0]} + 8'd8;
    endfunction

    task automatic step();
        @(posedge fps);
        #1;
        if (!freeze) nf++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x0e;
        logic [7:0] xe;
        int k;

        tbl[0] = '{1,   7'h00, 7'd0};
        tbl[1] = '{29,  7'h00, 7'd0};
        tbl[2] = '{30,  7'h01, 7'd112};
        tbl[3] = '{31,  7'h01, 7'd111};
        tbl[4] = '{60,  7'h03, 7'd82};
        tbl[5] = '{138, 7'h0F, 7'd4};
        tbl[6] = '{139, 7'h0E, 7'd4};
        tbl[7] = '{150, 7'h0F, 7'd112};

        reset  = 1'b1;
        freeze = 1'b0;
        swim_x = 8'd150;
        swim_y = 7'd0;
        #2;
        check("reset_active", 64'(bubble_active), 64'(7'h00));
        check("reset_coll",   64'(collisions),    64'(7'h00));
        check("reset_x",      64'(bubble_x),      64'(56'h0));
        check("reset_y",      64'(bubble_y),      64'(49'h0));
        #10;
        reset = 1'b0;

        // Spawn cadence, rise, retire and respawn into the freed slot 0.
        k = 0;
        for (int e = 1; e <= 150; e++) begin
            step();
            if (k < 8 && tbl[k].edge_n == nf) begin
                check($sformatf("tbl%0d_active", k), 64'(bubble_active),  64'(tbl[k].act));
                check($sformatf("tbl%0d_y0", k),     64'(bubble_y[6:0]),  64'(tbl[k].y0));
                check($sformatf("tbl%0d_coll", k),   64'(collisions),     64'(7'h00));
                k++;
            end
            if (nf == 30 || nf == 150) begin
                xe = spawn_x_at(nf);
                check("spawn_x0", 64'(bubble_x[7:0]), 64'(xe));
                check("spawn_x0_range", 64'(bubble_x[7:0] >= 8'd8 && bubble_x[7:0] <= 8'd135), 64'(1));
            end
            if (nf == 60) check("slot1_y", 64'(bubble_y[13:7]), 64'(7'd112));
        end

        // Collision is a one-frame-late level while the swimmer overlaps bubble 0.
        x0e    = spawn_x_at(150);
        swim_x = x0e;
        swim_y = 7'd108;
        for (int i = 0; i < 5; i++) begin
            step();
            check("coll_hold", 64'(collisions), 64'(7'h01));
        end
        swim_x = x0e + 8'd8;
        step();
        check("coll_release", 64'(collisions), 64'(7'h00));
        check("y0_pre_freeze", 64'(bubble_y[6:0]), 64'(7'd106));

        // Freeze with the swimmer overlapping: state holds and collisions stay low.
        swim_x = x0e;
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 9) begin
                check("frz_active", 64'(bubble_active), 64'(7'h0F));
                check("frz_y0",     64'(bubble_y[6:0]), 64'(7'd106));
                check("frz_x0",     64'(bubble_x[7:0]), 64'(x0e));
                check("frz_coll",   64'(collisions),    64'(7'h00));
            end
        end
        freeze = 1'b0;
        step();
        check("resume_coll", 64'(collisions),    64'(7'h01));
        check("resume_y0",   64'(bubble_y[6:0]), 64'(7'd105));
        swim_x = 8'd150;
        swim_y = 7'd0;
        while (nf < 179) step();
        check("pre_spawn_active", 64'(bubble_active), 64'(7'h0D));
        step();
        xe = spawn_x_at(180);
        check("reuse_active", 64'(bubble_active),   64'(7'h0F));
        check("reuse_y1",     64'(bubble_y[13:7]),  64'(7'd112));
        check("reuse_x1",     64'(bubble_x[15:8]),  64'(xe));
        check("reuse_y0",     64'(bubble_y[6:0]),   64'(7'd82));

        // Asynchronous reset between edges clears everything at once.
        #2;
        reset = 1'b1;
        #1;
        check("areset_active", 64'(bubble_active), 64'(7'h00));
        check("areset_x",      64'(bubble_x),      64'(56'h0));
        check("areset_y",      64'(bubble_y),      64'(49'h0));
        check("areset_coll",   64'(collisions),    64'(7'h00));
        check("areset_fast",   64'(f_act),         64'(7'h00));
        #1;
        reset = 1'b0;
        nf    = 0;

        // SPAWN_GAP=2 fill-up, then restarted cadence on the default instance.
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e <= 16) begin
                logic [7:0] exp_f;
                exp_f = (e / 2 >= 7) ? 8'h7F : 8'((1 << (e / 2)) - 1);
                check($sformatf("fast_active_e%0d", e), 64'(f_act), 64'(exp_f[6:0]));
            end
            if (e == 16) check("fast_y0", 64'(f_y[6:0]), 64'(7'd98));
            if (e == 29) check("restart_idle", 64'(bubble_active), 64'(7'h00));
        end
        xe = spawn_x_at(30);
        check("restart_active", 64'(bubble_active), 64'(7'h01));
        check("restart_x0",     64'(bubble_x[7:0]), 64'(xe));
        check("restart_y0",     64'(bubble_y[6:0]), 64'(7'd112));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
